// File: rtl/rename_pkg.sv
// Shared types for the register rename map table.
//   ARCH_REGS    : number of architectural registers (RV32: 32)
//   PHYS_W       : physical register address width used by the map storage;
//                  the top's PHYS_ADDR_WIDTH parameter must equal it
//   arch_idx_t   : architectural register index
//   phys_idx_t   : physical register index
//   map_state_t  : one complete mapping snapshot (map + ready per arch reg),
//                  used for the live table and for every checkpoint slot
//   reset_state(): identity mapping, everything ready
package rename_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_W    = 7;

    typedef logic [4:0]        arch_idx_t;
    typedef logic [PHYS_W-1:0] phys_idx_t;

    typedef struct packed {
        phys_idx_t [ARCH_REGS-1:0] map;
        logic      [ARCH_REGS-1:0] ready;
    } map_state_t;

    function automatic map_state_t reset_state();
        map_state_t s;
        for (int i = 0; i < ARCH_REGS; i++) begin
            s.map[i] = phys_idx_t'(i);
        end
        s.ready = '1;
        return s;
    endfunction

endpackage

// File: rtl/rename_wakeup.sv
// Wakeup merge for one mapping snapshot: every arch register whose physical
// mapping matches a valid writeback broadcast becomes ready.
//   state_i    : snapshot (map + current ready bits)
//   wb_valid_i : per-port broadcast valid
//   wb_phys_i  : per-port woken physical register
//   ready_o    : ready bits after this cycle's wakeups
module rename_wakeup
    import rename_pkg::*;
#(
    parameter int NUM_WB_PORTS = 2
) (
    input  map_state_t                   state_i,
    input  logic [NUM_WB_PORTS-1:0]      wb_valid_i,
    input  phys_idx_t [NUM_WB_PORTS-1:0] wb_phys_i,
    output logic [ARCH_REGS-1:0]         ready_o
);

    always_comb begin
        ready_o = state_i.ready;
        for (int r = 0; r < ARCH_REGS; r++) begin
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                if (wb_valid_i[k] && (state_i.map[r] == wb_phys_i[k])) begin
                    ready_o[r] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_rename_table.sv
// Rename map table with ready tracking, writeback wakeup, and a circular
// buffer of branch checkpoints with single-cycle restore.
//   arch_rs1/2 -> phys_rs1/2, ready_rs1/2 : combinational source lookup,
//                                           ready bypassed from this cycle's wb
//   rename_valid, arch_rd, new_phys_rd     : destination rename (x0 ignored)
//   old_phys_rd                            : previous mapping of arch_rd
//   wb_valid, wb_phys                      : wakeup broadcast ports (packed)
//   ckpt_save / ckpt_save_id / ckpt_full   : checkpoint allocation at tail
//   ckpt_release                           : free the oldest checkpoint
//   ckpt_restore / ckpt_restore_id         : mispredict restore
module reg_rename_table
    import rename_pkg::*;
#(
    parameter int PHYS_ADDR_WIDTH = PHYS_W,
    parameter int NUM_WB_PORTS    = 2,
    parameter int NUM_CHECKPOINTS = 4,
    parameter int CKPT_ID_WIDTH   = $clog2(NUM_CHECKPOINTS)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [4:0]                              arch_rs1,
    input  logic [4:0]                              arch_rs2,
    output logic [PHYS_ADDR_WIDTH-1:0]              phys_rs1,
    output logic [PHYS_ADDR_WIDTH-1:0]              phys_rs2,
    output logic                                    ready_rs1,
    output logic                                    ready_rs2,
    input  logic                                    rename_valid,
    input  logic [4:0]                              arch_rd,
    input  logic [PHYS_ADDR_WIDTH-1:0]              new_phys_rd,
    output logic [PHYS_ADDR_WIDTH-1:0]              old_phys_rd,
    input  logic [NUM_WB_PORTS-1:0]                 wb_valid,
    input  logic [NUM_WB_PORTS*PHYS_ADDR_WIDTH-1:0] wb_phys,
    input  logic                                    ckpt_save,
    output logic [CKPT_ID_WIDTH-1:0]                ckpt_save_id,
    output logic                                    ckpt_full,
    input  logic                                    ckpt_release,
    input  logic                                    ckpt_restore,
    input  logic [CKPT_ID_WIDTH-1:0]                ckpt_restore_id
);

    localparam int CNT_W = CKPT_ID_WIDTH + 1;
    typedef logic [CKPT_ID_WIDTH-1:0] ckpt_id_t;
    typedef logic [CNT_W-1:0]         ckpt_cnt_t;

    map_state_t live_q, live_d, post_st;
    map_state_t slot_q [NUM_CHECKPOINTS];
    map_state_t slot_d [NUM_CHECKPOINTS];
    ckpt_id_t   head_q, head_d, tail_q, tail_d, rst_off;
    ckpt_cnt_t  count_q, count_d;

    phys_idx_t [NUM_WB_PORTS-1:0] wb_phys_v;
    logic [ARCH_REGS-1:0]         live_woken;
    logic [ARCH_REGS-1:0]         slot_woken [NUM_CHECKPOINTS];
    logic                         do_ren, do_rel, do_save, byp1, byp2;

    assign wb_phys_v = wb_phys;

    // ---------------- wakeup: live table and every slot ----------------
    rename_wakeup #(.NUM_WB_PORTS(NUM_WB_PORTS)) u_live_wk (
        .state_i    (live_q),
        .wb_valid_i (wb_valid),
        .wb_phys_i  (wb_phys_v),
        .ready_o    (live_woken)
    );

    for (genvar g = 0; g < NUM_CHECKPOINTS; g++) begin : g_slot_wk
        rename_wakeup #(.NUM_WB_PORTS(NUM_WB_PORTS)) u_slot_wk (
            .state_i    (slot_q[g]),
            .wb_valid_i (wb_valid),
            .wb_phys_i  (wb_phys_v),
            .ready_o    (slot_woken[g])
        );
    end

    // ---------------- combinational reads ----------------
    always_comb begin
        phys_rs1    = (arch_rs1 == '0) ? '0 : live_q.map[arch_rs1];
        phys_rs2    = (arch_rs2 == '0) ? '0 : live_q.map[arch_rs2];
        old_phys_rd = (arch_rd  == '0) ? '0 : live_q.map[arch_rd];
        byp1 = 1'b0;
        byp2 = 1'b0;
        for (int k = 0; k < NUM_WB_PORTS; k++) begin
            if (wb_valid[k] && (wb_phys_v[k] == phys_rs1)) byp1 = 1'b1;
            if (wb_valid[k] && (wb_phys_v[k] == phys_rs2)) byp2 = 1'b1;
        end
        ready_rs1 = (arch_rs1 == '0) || live_q.ready[arch_rs1] || byp1;
        ready_rs2 = (arch_rs2 == '0) || live_q.ready[arch_rs2] || byp2;
    end

    // ---------------- control ----------------
    assign ckpt_full    = (count_q == ckpt_cnt_t'(NUM_CHECKPOINTS));
    assign ckpt_save_id = tail_q;
    assign do_ren  = rename_valid && (arch_rd != '0) && !ckpt_restore;
    assign do_rel  = ckpt_release && (count_q != '0);
    // A release frees the head slot on this edge, so a full buffer can still
    // accept a save in the same cycle (it reuses the slot being freed).
    assign do_save = ckpt_save && !ckpt_restore && (!ckpt_full || do_rel);
    // Distance of the restored slot from the oldest live one (mod N).
    assign rst_off = ckpt_restore_id - head_q;

    // Live state as it will look after this edge when no restore happens;
    // this is also what a save captures. Rename overrides a same-edge wakeup.
    always_comb begin
        post_st       = live_q;
        post_st.ready = live_woken;
        if (do_ren) begin
            post_st.map[arch_rd]   = new_phys_rd;
            post_st.ready[arch_rd] = 1'b0;
        end
    end

    always_comb begin
        live_d  = post_st;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
            slot_d[i]       = slot_q[i];
            slot_d[i].ready = slot_woken[i];
        end
        if (do_rel) head_d = head_q + ckpt_id_t'(1);
        if (ckpt_restore) begin
            live_d.map   = slot_q[ckpt_restore_id].map;
            live_d.ready = slot_woken[ckpt_restore_id];
            tail_d       = ckpt_restore_id + ckpt_id_t'(1);
            // Slots head..restore_id stay live; a concurrent release drops head.
            count_d      = ckpt_cnt_t'({1'b0, rst_off}) + ckpt_cnt_t'(1)
                           - ckpt_cnt_t'(do_rel);
        end else begin
            if (do_save) begin
                slot_d[tail_q] = post_st;
                tail_d         = tail_q + ckpt_id_t'(1);
            end
            count_d = count_q + ckpt_cnt_t'(do_save) - ckpt_cnt_t'(do_rel);
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_q  <= reset_state();
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Slot contents are only meaningful once saved, so they carry no reset.
    always_ff @(posedge clock) begin
        slot_q <= slot_d;
    end

    // ---------------- protocol checks ----------------
    a_save_full: assert property (@(posedge clock) disable iff (reset)
        !(ckpt_save && !ckpt_restore && ckpt_full && !ckpt_release));
    a_rel_empty: assert property (@(posedge clock) disable iff (reset)
        !(ckpt_release && (count_q == '0)));
    a_rst_live: assert property (@(posedge clock) disable iff (reset)
        ckpt_restore |-> (ckpt_cnt_t'({1'b0, rst_off}) < count_q));

endmodule

// File: tb/tb_reg_rename_table.sv
module tb_reg_rename_table;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  arch_rs1, arch_rs2, arch_rd;
    logic [6:0]  phys_rs1, phys_rs2, new_phys_rd, old_phys_rd;
    logic        ready_rs1, ready_rs2, rename_valid;
    logic [1:0]  wb_valid;
    logic [13:0] wb_phys;
    logic        ckpt_save, ckpt_full, ckpt_release, ckpt_restore;
    logic [1:0]  ckpt_save_id, ckpt_restore_id;

    reg_rename_table dut (
        .clock(clock), .reset(reset),
        .arch_rs1(arch_rs1), .arch_rs2(arch_rs2),
        .phys_rs1(phys_rs1), .phys_rs2(phys_rs2),
        .ready_rs1(ready_rs1), .ready_rs2(ready_rs2),
        .rename_valid(rename_valid), .arch_rd(arch_rd),
        .new_phys_rd(new_phys_rd), .old_phys_rd(old_phys_rd),
        .wb_valid(wb_valid), .wb_phys(wb_phys),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id), .ckpt_full(ckpt_full),
        .ckpt_release(ckpt_release), .ckpt_restore(ckpt_restore),
        .ckpt_restore_id(ckpt_restore_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       rv;
        logic [4:0] rd;
        logic [6:0] np;
        logic [1:0] wbv;
        logic [6:0] wb0, wb1;
        logic       sv, rl, rs;
        logic [1:0] rid;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] p1, p2, old;
        logic       r1, r2, full;
        logic [1:0] sid;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(int rs1, int rs2, int rv, int rd, int np, int wbv, int wb0,
                                int wb1, int sv, int rl, int rs, int rid, int p1, int r1,
                                int p2, int r2, int old, int sid, int full);
        vec_t v;
        v.in.rs1 = rs1[4:0]; v.in.rs2 = rs2[4:0]; v.in.rv = rv[0]; v.in.rd = rd[4:0];
        v.in.np = np[6:0]; v.in.wbv = wbv[1:0]; v.in.wb0 = wb0[6:0]; v.in.wb1 = wb1[6:0];
        v.in.sv = sv[0]; v.in.rl = rl[0]; v.in.rs = rs[0]; v.in.rid = rid[1:0];
        v.p1 = p1[6:0]; v.r1 = r1[0]; v.p2 = p2[6:0]; v.r2 = r2[0];
        v.old = old[6:0]; v.sid = sid[1:0]; v.full = full[0];
        return v;
    endfunction

    task automatic drive(input in_t i);
        arch_rs1 = i.rs1; arch_rs2 = i.rs2;
        rename_valid = i.rv; arch_rd = i.rd; new_phys_rd = i.np;
        wb_valid = i.wbv; wb_phys = {i.wb1, i.wb0};
        ckpt_save = i.sv; ckpt_release = i.rl;
        ckpt_restore = i.rs; ckpt_restore_id = i.rid;
    endtask

    task automatic check_outs(input string tag, input logic [6:0] p1, input logic r1,
                              input logic [6:0] p2, input logic r2, input logic [6:0] old,
                              input logic [1:0] sid, input logic full);
        chk({tag, ".phys_rs1"}, 32'(phys_rs1), 32'(p1));
        chk({tag, ".ready_rs1"}, 32'(ready_rs1), 32'(r1));
        chk({tag, ".phys_rs2"}, 32'(phys_rs2), 32'(p2));
        chk({tag, ".ready_rs2"}, 32'(ready_rs2), 32'(r2));
        chk({tag, ".old_phys_rd"}, 32'(old_phys_rd), 32'(old));
        chk({tag, ".ckpt_save_id"}, 32'(ckpt_save_id), 32'(sid));
        chk({tag, ".ckpt_full"}, 32'(ckpt_full), 32'(full));
    endtask

    task automatic do_reset();
        in_t idle;
        idle = '{default: '0};
        drive(idle);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // ---------------- reference model: queue of checkpoint records ----------------
    typedef struct packed {
        logic [1:0]       id;
        logic [31:0][6:0] map;
        logic [31:0]      rdy;
    } ck_t;

    logic [31:0][6:0] m_map;
    logic [31:0]      m_rdy;
    ck_t              mq[$];
    int               m_next;

    function automatic bit hit(input in_t i, input logic [6:0] p);
        return (i.wbv[0] && i.wb0 == p) || (i.wbv[1] && i.wb1 == p);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_map[r] = 7'(r);
        m_rdy = '1;
        mq.delete();
        m_next = 0;
    endtask

    task automatic model_step(input in_t i);
        ck_t t;
        int  j;
        for (int e = 0; e < mq.size(); e++) begin
            t = mq[e];
            for (int r = 0; r < 32; r++) if (hit(i, t.map[r])) t.rdy[r] = 1'b1;
            mq[e] = t;
        end
        if (i.rs) begin
            j = 0;
            for (int e = 0; e < mq.size(); e++) if (mq[e].id == i.rid) j = e;
            m_map = mq[j].map;
            m_rdy = mq[j].rdy;
            while (mq.size() > j + 1) void'(mq.pop_back());
            m_next = (int'(i.rid) + 1) % 4;
            if (i.rl) void'(mq.pop_front());
        end else begin
            for (int r = 0; r < 32; r++) if (hit(i, m_map[r])) m_rdy[r] = 1'b1;
            if (i.rv && i.rd != 0) begin
                m_map[i.rd] = i.np;
                m_rdy[i.rd] = 1'b0;
            end
            if (i.rl && mq.size() > 0) void'(mq.pop_front());
            if (i.sv && mq.size() < 4) begin
                t.id = 2'(m_next); t.map = m_map; t.rdy = m_rdy;
                mq.push_back(t);
                m_next = (m_next + 1) % 4;
            end
        end
    endtask

    vec_t vt[20];

    initial begin
        in_t ri;
        logic [6:0] e1, e2;

        // ---------- table: directed sequence from reset ----------
        //          rs1 rs2 rv rd np  wbv wb0 wb1 sv rl rs rid | p1 r1 p2 r2 old sid full
        vt[0]  = mk(5,  7,  0, 0, 0,  0,  0,  0,  0, 0, 0, 0,   5, 1, 7, 1,  0,  0, 0);
        vt[1]  = mk(0,  0,  1, 0, 40, 0,  0,  0,  0, 0, 0, 0,   0, 1, 0, 1,  0,  0, 0);
        vt[2]  = mk(0,  3,  1, 3, 40, 0,  0,  0,  0, 0, 0, 0,   0, 1, 3, 1,  3,  0, 0);
        vt[3]  = mk(3,  3,  0, 3, 0,  0,  0,  0,  0, 0, 0, 0,  40, 0, 40, 0, 40, 0, 0);
        vt[4]  = mk(3,  4,  1, 4, 41, 3,  40, 41, 0, 0, 0, 0,  40, 1, 4, 1,  4,  0, 0);
        vt[5]  = mk(3,  4,  0, 4, 0,  0,  0,  0,  0, 0, 0, 0,  40, 1, 41, 0, 41, 0, 0);
        vt[6]  = mk(3,  4,  0, 4, 0,  0,  0,  0,  1, 0, 0, 0,  40, 1, 41, 0, 41, 0, 0);
        vt[7]  = mk(3,  4,  1, 3, 50, 0,  0,  0,  0, 0, 0, 0,  40, 1, 41, 0, 40, 1, 0);
        vt[8]  = mk(3,  4,  1, 4, 51, 1,  41, 0,  0, 0, 0, 0,  50, 0, 41, 1, 41, 1, 0);
        vt[9]  = mk(3,  4,  1, 6, 60, 0,  0,  0,  1, 0, 1, 0,  50, 0, 51, 0,  6, 1, 0);
        vt[10] = mk(3,  4,  0, 6, 0,  0,  0,  0,  0, 0, 0, 0,  40, 1, 41, 1,  6, 1, 0);
        vt[11] = mk(3,  4,  0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  40, 1, 41, 1,  0, 1, 0);
        vt[12] = mk(3,  4,  0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  40, 1, 41, 1,  0, 2, 0);
        vt[13] = mk(3,  4,  0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  40, 1, 41, 1,  0, 3, 0);
        vt[14] = mk(3,  4,  0, 0, 0,  0,  0,  0,  1, 1, 0, 0,  40, 1, 41, 1,  0, 0, 1);
        vt[15] = mk(3,  7,  1, 7, 70, 0,  0,  0,  0, 1, 0, 0,  40, 1, 7, 1,   7, 1, 1);
        vt[16] = mk(3,  7,  0, 7, 0,  0,  0,  0,  0, 0, 1, 3,  40, 1, 70, 0, 70, 1, 0);
        vt[17] = mk(3,  7,  0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  40, 1, 7, 1,   0, 0, 0);
        vt[18] = mk(3,  7,  0, 0, 0,  0,  0,  0,  1, 0, 0, 0,  40, 1, 7, 1,   0, 1, 0);
        vt[19] = mk(3,  7,  0, 0, 0,  0,  0,  0,  0, 0, 0, 0,  40, 1, 7, 1,   0, 2, 1);

        do_reset();
        // reset state: identity map, all ready
        for (int r = 0; r < 32; r++) begin
            arch_rs1 = 5'(r);
            #1;
            chk($sformatf("reset.map%0d", r), 32'(phys_rs1), 32'(r));
            chk($sformatf("reset.rdy%0d", r), 32'(ready_rs1), 32'd1);
        end
        @(negedge clock);

        for (int v = 0; v < 20; v++) begin
            drive(vt[v].in);
            #2;
            check_outs($sformatf("vec%0d", v), vt[v].p1, vt[v].r1, vt[v].p2, vt[v].r2,
                       vt[v].old, vt[v].sid, vt[v].full);
            @(negedge clock);
        end

        // ---------- hand sequence: restore + release on the oldest slot ----------
        do_reset();
        ri = '{default: '0};
        ri.sv = 1; drive(ri); #2;
        chk("hs.sid0", 32'(ckpt_save_id), 32'd0);
        @(negedge clock);
        #2; chk("hs.sid1", 32'(ckpt_save_id), 32'd1);
        @(negedge clock);
        ri.sv = 0; ri.rs = 1; ri.rid = 0; ri.rl = 1; drive(ri); #2;
        chk("hs.sid2", 32'(ckpt_save_id), 32'd2);
        @(negedge clock);
        ri = '{default: '0}; ri.sv = 1; drive(ri);
        for (int s = 0; s < 4; s++) begin
            #2;
            chk($sformatf("hs.fill%0d.sid", s), 32'(ckpt_save_id), 32'((s + 1) % 4));
            chk($sformatf("hs.fill%0d.full", s), 32'(ckpt_full), 32'd0);
            @(negedge clock);
        end
        ri.sv = 0; drive(ri); #2;
        chk("hs.full", 32'(ckpt_full), 32'd1);
        chk("hs.full.sid", 32'(ckpt_save_id), 32'd1);
        @(negedge clock);

        // ---------- randomized against the reference model ----------
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            ri.rs1 = 5'($urandom_range(0, 31));
            ri.rs2 = 5'($urandom_range(0, 31));
            ri.rv  = 1'($urandom_range(0, 1));
            ri.rd  = 5'($urandom_range(0, 31));
            ri.np  = 7'($urandom_range(32, 47));
            ri.wbv = 2'($urandom_range(0, 3));
            ri.wb0 = 7'($urandom_range(0, 47));
            ri.wb1 = 7'($urandom_range(28, 47));
            ri.rl  = (mq.size() > 0) && ($urandom_range(0, 3) == 0);
            ri.sv  = ($urandom_range(0, 2) == 0) && (mq.size() < 4 || ri.rl);
            ri.rs  = (mq.size() > 0) && ($urandom_range(0, 7) == 0);
            ri.rid = ri.rs ? mq[$urandom_range(0, mq.size() - 1)].id : 2'($urandom_range(0, 3));
            drive(ri);
            #2;
            e1 = (ri.rs1 == 0) ? 7'd0 : m_map[ri.rs1];
            e2 = (ri.rs2 == 0) ? 7'd0 : m_map[ri.rs2];
            check_outs($sformatf("rnd%0d", c), e1,
                       (ri.rs1 == 0) || m_rdy[ri.rs1] || hit(ri, e1), e2,
                       (ri.rs2 == 0) || m_rdy[ri.rs2] || hit(ri, e2),
                       (ri.rd == 0) ? 7'd0 : m_map[ri.rd], 2'(m_next), mq.size() == 4);
            model_step(ri);
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_rename_table.md
Name: reg_rename_table

Overview:
Parametrised rename map table for the out-of-order RV32 core, between decode and dispatch. Maps 32 architectural registers to physical register file addresses and tracks a ready bit per mapping. Adds writeback wakeup broadcast, old-mapping return for freelist recycling, and a circular buffer of branch checkpoints with single-cycle mispredict restore.

Parameters:
PHYS_ADDR_WIDTH, 7, physical register file address width
NUM_WB_PORTS, 2, number of writeback wakeup broadcast ports
NUM_CHECKPOINTS, 4, checkpoint slots; power of two, at least 2
CKPT_ID_WIDTH, $clog2(NUM_CHECKPOINTS), checkpoint id width

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high
arch_rs1  in  5  source 1 architectural index
arch_rs2  in  5  source 2 architectural index
phys_rs1  out  PHYS_ADDR_WIDTH  current mapping of rs1
phys_rs2  out  PHYS_ADDR_WIDTH  current mapping of rs2
ready_rs1  out  1  rs1 value available, wakeup-bypassed
ready_rs2  out  1  rs2 value available, wakeup-bypassed
rename_valid  in  1  rename arch_rd this cycle
arch_rd  in  5  destination architectural index
new_phys_rd  in  PHYS_ADDR_WIDTH  physical register allocated from the freelist
old_phys_rd  out  PHYS_ADDR_WIDTH  mapping of arch_rd before rename, freed at commit
wb_valid  in  NUM_WB_PORTS  wakeup valid per port
wb_phys  in  NUM_WB_PORTS*PHYS_ADDR_WIDTH  woken physical register per port, packed
ckpt_save  in  1  take checkpoint, only when ckpt_full==0
ckpt_save_id  out  CKPT_ID_WIDTH  slot id used by this cycle's save
ckpt_full  out  1  no free slot
ckpt_release  in  1  oldest checkpoint's branch resolved correctly; free it
ckpt_restore  in  1  mispredict: restore slot ckpt_restore_id
ckpt_restore_id  in  CKPT_ID_WIDTH  slot to restore

Behaviour:
- Reset, asynchronous: map[i]=i; ready[i]=1; head=tail=0; count=0; ckpt_full=0; slot contents don't-care.
- Reads are combinational from the current state.
- ready_rsN = ready[arch_rsN] OR any wb_valid[k] with wb_phys[k]==phys_rsN. This is a same-cycle bypass.
- old_phys_rd = map[arch_rd], combinational.
- x0: always reads phys 0, ready 1. Renames with arch_rd==0 are ignored and produce no state change. old_phys_rd=0.
- Rename, on the clock edge: map[arch_rd]<=new_phys_rd; ready[arch_rd]<=0.
- Wakeup, on the clock edge: for every arch r with map[r]==wb_phys[k] and wb_valid[k], set ready[r]<=1. The same update applies to the ready copies in every valid checkpoint slot.
- Rename and wakeup hit the same arch reg: rename wins, so ready becomes 0.
- Checkpoint save writes slot[tail] with the post-edge state, meaning this cycle's rename and wakeups are included. Then tail++ (mod N) and count++. ckpt_save_id=tail.
- ckpt_full = (count==NUM_CHECKPOINTS).
- Save while full is ignored. Flag it with an assertion.
- Release: head++ and count--. Release while empty is ignored and asserted.
- Save and release in the same cycle: count unchanged, both pointers advance.
- Restore, on the clock edge:
  - map and ready are loaded from slot[ckpt_restore_id], with this cycle's wakeups applied on top.
  - tail<=ckpt_restore_id+1. The restored slot stays live until its branch is released.
  - count<=(ckpt_restore_id-head mod N)+1.
  - Restore overrides rename and save in the same cycle; both are dropped.
  - Restore and release in the same cycle: head advances as well.
- Restore of a non-live id is a protocol error and is asserted.
- Wrap-around: pointers are CKPT_ID_WIDTH bits and wrap naturally. Full and empty are distinguished by count, which is CKPT_ID_WIDTH+1 bits wide.
- Latency: all state changes are visible on the outputs one cycle after the edge. There are no stall outputs other than ckpt_full.

Decomposition:
- Shared package rename_pkg holds: ARCH_REGS=32, the arch index typedef, the phys index typedef parameterised by PHYS_ADDR_WIDTH, and a map_state_t struct {map[32], ready[32]} used by both the live table and the slots.
- One sub-module, rename_wakeup, computes the next ready vector from a map_state_t and the wb ports. It is instantiated once for the live table and once per checkpoint slot.

Test Plan:
- Reset then read arch 5/7 -> phys_rs1=5, phys_rs2=7, both ready. Rename x0->40 -> phys x0 still 0, ready 1.
- Rename x3->40 -> old_phys_rd=3; next cycle phys 40, ready 0. wb_phys=40 valid -> bypass ready_rs1=1 same cycle, latched next cycle.
- Rename x4->41 with wb_phys=41 on the same edge -> ready[x4]=0 afterwards.
- Save ckpt (id 0), rename x3->50, wakeup 40, restore id 0 -> x3 maps 40, ready 1, tail=1, count=1.
- Fill 4 saves -> ckpt_full=1, ids 0..3. A 5th save is ignored. Release+save same cycle -> id 0 reused, count stays 4.
- head=2 after wrap, 3 live slots (2,3,0), restore id 3 -> count=2, tail=0. A subsequent save returns id 0.
